// File: rtl/uart_alu_ctrl.sv
// Frame sequencer between the UART and the combinational ALU:
// gathers A, B and opcode bytes, then sends the ALU result back over TX.
module uart_alu_ctrl #(
    parameter int          NBIT_DATA      = 8,
    parameter int          NBIT_OP        = 6,
    parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
    input  logic                 CLK,
    input  logic                 reset,
    input  logic [NBIT_DATA-1:0] rx_data,
    input  logic                 rx_done_tick,
    input  logic                 tx_done_tick,
    input  logic [NBIT_DATA-1:0] alu_result,
    output logic [NBIT_DATA-1:0] alu_a,
    output logic [NBIT_DATA-1:0] alu_b,
    output logic [NBIT_OP-1:0]   alu_op,
    output logic [NBIT_DATA-1:0] tx_data,
    output logic                 tx_start,
    output logic                 busy,
    output logic                 overrun,
    output logic                 timeout
);

    localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        WAIT_A,
        WAIT_B,
        WAIT_OP,
        LOAD,
        WAIT_TX
    } state_e;

    state_e                 state_q, state_d;
    logic [31:0]            timer_q, timer_d;
    logic [NBIT_DATA-1:0]   a_q, a_d;
    logic [NBIT_DATA-1:0]   b_q, b_d;
    logic [NBIT_OP-1:0]     op_q, op_d;
    logic [NBIT_DATA-1:0]   txd_q, txd_d;
    logic                   start_q, start_d;
    logic                   busy_q, busy_d;
    logic                   ovr_q, ovr_d;
    logic                   to_q, to_d;
    logic                   expired;

    assign expired = TO_EN && (timer_q == TO_LAST);

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q <= WAIT_A;
            timer_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            txd_q   <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            txd_q   <= txd_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            ovr_q   <= ovr_d;
            to_q    <= to_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        txd_d   = txd_q;
        start_d = 1'b0;
        busy_d  = busy_q;
        ovr_d   = ovr_q;
        to_d    = 1'b0;
        unique case (state_q)
            WAIT_A: begin
                timer_d = '0;
                if (rx_done_tick) begin
                    a_d     = rx_data;
                    state_d = WAIT_B;
                end
            end
            WAIT_B: begin
                // A byte arriving on the expiry cycle still counts.
                if (rx_done_tick) begin
                    b_d     = rx_data;
                    timer_d = '0;
                    state_d = WAIT_OP;
                end else if (expired) begin
                    timer_d = '0;
                    to_d    = 1'b1;
                    state_d = WAIT_A;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            WAIT_OP: begin
                if (rx_done_tick) begin
                    op_d    = rx_data[NBIT_OP-1:0];
                    busy_d  = 1'b1;
                    timer_d = '0;
                    state_d = LOAD;
                end else if (expired) begin
                    timer_d = '0;
                    to_d    = 1'b1;
                    state_d = WAIT_A;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            LOAD: begin
                txd_d   = alu_result;
                start_d = 1'b1;
                state_d = WAIT_TX;
                if (rx_done_tick) ovr_d = 1'b1;
            end
            WAIT_TX: begin
                if (rx_done_tick) ovr_d = 1'b1;
                if (tx_done_tick) begin
                    busy_d  = 1'b0;
                    timer_d = '0;
                    state_d = WAIT_A;
                end
            end
            default: begin
                timer_d = '0;
                state_d = WAIT_A;
            end
        endcase
    end

    assign alu_a    = a_q;
    assign alu_b    = b_q;
    assign alu_op   = op_q;
    assign tx_data  = txd_q;
    assign tx_start = start_q;
    assign busy     = busy_q;
    assign overrun  = ovr_q;
    assign timeout  = to_q;

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Randomised frame bench for uart_alu_ctrl with a behavioural ALU
// and expected results computed from the bytes that were sent.
module tb_uart_alu_ctrl;

    logic       CLK = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_done_tick;
    logic       tx_done_tick;
    logic [7:0] alu_result;
    logic [7:0] alu_a, alu_b, tx_data;
    logic [5:0] alu_op;
    logic       tx_start, busy, overrun, timeout;

    int total = 0;
    int bad = 0;
    int pulses = 0;
    int exp_pulses = 0;
    int dbl = 0;
    int to_cnt = 0;
    logic prev_start = 1'b0;

    always #5 CLK = ~CLK;

    uart_alu_ctrl #(
        .NBIT_DATA(8),
        .NBIT_OP(6),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .CLK(CLK),
        .reset(reset),
        .rx_data(rx_data),
        .rx_done_tick(rx_done_tick),
        .tx_done_tick(tx_done_tick),
        .alu_result(alu_result),
        .alu_a(alu_a),
        .alu_b(alu_b),
        .alu_op(alu_op),
        .tx_data(tx_data),
        .tx_start(tx_start),
        .busy(busy),
        .overrun(overrun),
        .timeout(timeout)
    );

    function automatic logic [7:0] alu_f(logic [7:0] a, logic [7:0] b,
                                         logic [5:0] op);
        case (op)
            6'h20: return a + b;
            6'h22: return a - b;
            6'h24: return a & b;
            6'h25: return a | b;
            6'h26: return a ^ b;
            6'h27: return ~(a | b);
            6'h03: return 8'($signed(a) >>> b[2:0]);
            6'h02: return a >> b[2:0];
            default: return 8'h00;
        endcase
    endfunction

    assign alu_result = alu_f(alu_a, alu_b, alu_op);

    always @(negedge CLK) begin
        if (tx_start) pulses++;
        if (tx_start && prev_start) dbl++;
        if (timeout) to_cnt++;
        prev_start <= tx_start;
    end

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(logic [7:0] b);
        rx_data = b;
        rx_done_tick = 1'b1;
        @(negedge CLK);
        rx_done_tick = 1'b0;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) @(negedge CLK);
    endtask

    task automatic finish_frame(logic [7:0] exp, int dly,
                                bit ovr, logic [7:0] ovrb);
        chk("start_early", tx_start, 0);
        chk("busy_load", busy, 1);
        @(negedge CLK);
        chk("start_pulse", tx_start, 1);
        chk("tx_data", tx_data, exp);
        exp_pulses++;
        @(negedge CLK);
        chk("start_drop", tx_start, 0);
        for (int i = 0; i < dly; i++) begin
            if (ovr && i == 1) begin
                send_byte(ovrb);
                chk("ovr_set", overrun, 1);
            end else begin
                @(negedge CLK);
            end
        end
        chk("busy_tx", busy, 1);
        tx_done_tick = 1'b1;
        @(negedge CLK);
        tx_done_tick = 1'b0;
        chk("busy_done", busy, 0);
    endtask

    task automatic frame(logic [7:0] a, logic [7:0] b, logic [7:0] opb,
                         int dly, bit ovr);
        logic [7:0] exp;
        exp = alu_f(a, b, opb[5:0]);
        send_byte(a);
        idle($urandom_range(0, 5));
        send_byte(b);
        idle($urandom_range(0, 5));
        send_byte(opb);
        chk("alu_a", alu_a, a);
        chk("alu_b", alu_b, b);
        chk("alu_op", alu_op, opb[5:0]);
        finish_frame(exp, dly, ovr, 8'h02);
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_a"}, alu_a, 0);
        chk({tag, "_b"}, alu_b, 0);
        chk({tag, "_op"}, alu_op, 0);
        chk({tag, "_txd"}, tx_data, 0);
        chk({tag, "_start"}, tx_start, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_ovr"}, overrun, 0);
        chk({tag, "_to"}, timeout, 0);
    endtask

    logic [5:0] codes [8] = '{6'h20, 6'h22, 6'h24, 6'h25,
                              6'h26, 6'h27, 6'h03, 6'h02};

    initial begin
        int n;
        logic [7:0] a, b, opb;
        reset = 1'b1;
        rx_data = '0;
        rx_done_tick = 1'b0;
        tx_done_tick = 1'b0;
        idle(3);
        chk_zero("rst");
        reset = 1'b0;
        @(negedge CLK);

        frame(8'h05, 8'h03, 8'h20, 10, 0);

        send_byte(8'h11);
        n = 0;
        while (!timeout && n < 200) begin
            @(negedge CLK);
            n++;
        end
        chk("to_cycles", n, 100);
        @(negedge CLK);
        chk("to_single", timeout, 0);
        chk("to_hold_a", alu_a, 8'h11);
        chk("to_hold_b", alu_b, 8'h03);
        frame(8'h02, 8'h04, 8'h20, 10, 0);

        send_byte(8'h40);
        idle(99);
        send_byte(8'h07);
        chk("edge_no_to", timeout, 0);
        chk("edge_b", alu_b, 8'h07);
        send_byte(8'h20);
        finish_frame(8'h47, 10, 0, 8'h00);

        frame(8'h09, 8'h09, 8'h22, 10, 1);
        frame(8'h01, 8'h01, 8'h20, 10, 0);
        chk("ovr_sticky", overrun, 1);

        send_byte(8'hA5);
        send_byte(8'h5A);
        @(negedge CLK);
        #2 reset = 1'b1;
        #1 chk_zero("amid");
        @(negedge CLK);
        reset = 1'b0;
        frame(8'h0F, 8'hF0, 8'h25, 10, 0);

        send_byte(8'h03);
        send_byte(8'h04);
        send_byte(8'h20);
        @(negedge CLK);
        chk("cut_pre", tx_start, 1);
        exp_pulses++;
        #2 reset = 1'b1;
        #1 chk("cut_start", tx_start, 0);
        chk("cut_busy", busy, 0);
        @(negedge CLK);
        reset = 1'b0;

        tx_done_tick = 1'b1;
        @(negedge CLK);
        tx_done_tick = 1'b0;
        chk("txd_idle", busy, 0);

        for (int k = 0; k < 30; k++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            opb = {2'($urandom), codes[$urandom_range(0, 7)]};
            frame(a, b, opb, (k < 10) ? 10 : $urandom_range(1, 12), 0);
        end

        idle(3);
        chk("pulses", pulses, exp_pulses);
        chk("double", dbl, 0);
        chk("to_count", to_cnt, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
